pkt_rx_proc: RTL and testbench
==============================

Name: pkt_rx_proc

Overview:
- Receive-side packet processor for the NI: the NoC -> AXI counterpart of the AXI -> NoC packetizer.
- Accepts flits from the router local output port and tracks packet framing per virtual channel (head/body/tail against the head-flit size field).
- Strips the flit type and forwards payload through a one-entry registered output stage to the AXI RX buffers.
- Raises sticky framing-error flags and counts completed packets.

Parameters:
NumVirtChn, 3, number of virtual channels; VcW = $clog2(NumVirtChn)
FlitWidth, 34, full flit width including the 2-bit type
FlitDataWidth, 32, payload width (FlitWidth-2)
PktWidth, 8, packet-size field width in the head flit
XWidth, 2, destination-X field width
YWidth, 2, destination-Y field width

Ports:
clk_axi  in  1  clock; the block's single clock
arst_axi  in  1  asynchronous, active-high reset
flit_valid_i  in  1  flit present from router
flit_data_i  in  FlitWidth  flit; [FlitWidth-1:FlitWidth-2] is the type
flit_vc_i  in  VcW  VC of the flit
flit_ready_o  out  1  flit accepted when valid&&ready
rx_valid_o  out  1  payload valid to RX buffer
rx_data_o  out  FlitDataWidth  flit with type stripped
rx_vc_o  out  VcW  destination RX buffer select
rx_last_o  out  1  final flit of the packet
rx_ready_i  in  1  RX buffer accepts
pkt_done_o  out  1  one-cycle pulse when a last flit transfers on rx
pkt_done_vc_o  out  VcW  VC of the completed packet
err_o  out  3  sticky flags: [0] unexpected head, [1] orphan body/tail, [2] length mismatch
clr_err_i  in  1  clears err_o on the next edge
pkt_total_o  out  16  completed packets, saturating at 16'hFFFF

Behaviour:
- Reset: all outputs 0; every VC in IDLE with remaining=0; output stage empty; err=0; pkt_total=0.
- Head-flit layout: type, then x_dest, then y_dest, then pkt_sz (PktWidth), then payload, MSB-first below the type field.
- Type encodings come from ravenoc_pkg: HEAD_FLIT, BODY_FLIT, TAIL_FLIT.
- Output stage: flit_ready_o = ~out_valid_ff | rx_ready_i, combinational.
  - An accepted flit appears on rx_* the next cycle (latency 1).
  - Output holds stable while rx_valid_o && ~rx_ready_i.
  - Full throughput: accept and drain in the same cycle.
- Per-VC FSM (IDLE, BODY) with remaining counter; only the VC selected by flit_vc_i advances, and only on accept.
  - IDLE + HEAD, pkt_sz==0: single-flit packet; rx_last=1; stay IDLE.
  - IDLE + HEAD, pkt_sz>0: remaining=pkt_sz; go to BODY; rx_last=0.
  - IDLE + BODY/TAIL: flit dropped (accepted, not forwarded); err[1] set.
  - BODY + BODY, remaining>1: remaining-1; forward.
  - BODY + BODY, remaining==1: forward with rx_last=1; err[2] set; go to IDLE.
  - BODY + TAIL, remaining==1: forward with rx_last=1; go to IDLE (normal end).
  - BODY + TAIL, remaining>1: premature tail; forward with rx_last=1; err[2] set; go to IDLE.
  - BODY + HEAD: err[0] set; old packet abandoned without a last flit; process as a new head from IDLE.
- Type 2'b11: dropped and treated as orphan; err[1] set.
- pkt_done_o fires on the cycle rx_valid_o && rx_ready_i && rx_last_o. pkt_total increments on the same cycle, saturating.
- Error flags: set has priority over clr_err_i in the same cycle. flit_data_i[FlitDataWidth-1:0] is forwarded unchanged, head flits included.
- VC flits may interleave arbitrarily; each VC's state is independent.
- Reset mid-packet: all state returns to IDLE; any pending output is discarded.

Decomposition:
- ravenoc_pkg: add s_head_flit_t packed struct (type, x_dest, y_dest, pkt_sz, payload), rx_err_t bit indices, and RxErrUnexpHead/RxErrOrphan/RxErrLen constants. Reuse the existing flit-type enum.
- Sub-module pkt_rx_vc_fsm: one instance per VC, generated in a loop. It holds the state and remaining counter and outputs fwd/last/err strobes.
- The top level holds the output register, error flags and packet counter.

Test Plan:
- VC0: HEAD pkt_sz=2, BODY, TAIL, rx_ready=1 -> 3 rx beats one cycle after each accept; rx_last only on TAIL; pkt_done with vc=0; pkt_total=1; err=0.
- HEAD pkt_sz=0 on VC2 -> single rx beat with rx_last=1; pkt_done_vc_o=2.
- Interleaved VC0/VC1: H0 H1 B0 B1 T1 T0 with pkt_sz=2 each -> two pkt_done pulses, VC1 first; no errors.
- rx_ready_i=0 for 5 cycles during a packet -> flit_ready_o=0 after the first stored flit; rx_data stable; no loss; order preserved after release.
- Orphan TAIL on idle VC1 -> no rx beat; err_o=3'b010; clr_err_i -> 0. HEAD pkt_sz=3 then TAIL -> rx_last on TAIL; err_o[2]=1.
- HEAD, HEAD on VC0 -> err_o[0]=1; second packet completes normally. arst_axi mid-packet -> outputs 0 and VC back to IDLE.

Source files
------------

// File: rtl/ravenoc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ravenoc_pkg
// Description : Shared NoC types: flit encodings, head-flit layout, RX error
//               bit positions and receive-side VC state encoding.
// Revision    : 1.0 - initial receive-path additions
// ============================================================================
package ravenoc_pkg;

    localparam int NocNumVirtChn    = 3;
    localparam int NocFlitWidth     = 34;
    localparam int NocFlitDataWidth = NocFlitWidth - 2;
    localparam int NocPktWidth      = 8;
    localparam int NocXWidth        = 2;
    localparam int NocYWidth        = 2;
    localparam int NocVcW           = $clog2(NocNumVirtChn);
    localparam int NocPayloadW      = NocFlitDataWidth - NocXWidth - NocYWidth - NocPktWidth;

    typedef enum logic [1:0] {
        HEAD_FLIT = 2'b00,
        BODY_FLIT = 2'b01,
        TAIL_FLIT = 2'b10
    } flit_type_t;

    typedef struct packed {
        flit_type_t                    flit_type;
        logic [NocXWidth-1:0]          x_dest;
        logic [NocYWidth-1:0]          y_dest;
        logic [NocPktWidth-1:0]        pkt_sz;
        logic [NocPayloadW-1:0]        payload;
    } s_head_flit_t;

    // Bit positions inside the sticky receive error vector
    typedef logic [2:0] rx_err_t;
    localparam int RxErrUnexpHead = 0;
    localparam int RxErrOrphan    = 1;
    localparam int RxErrLen       = 2;

    typedef enum logic [0:0] {
        VC_IDLE = 1'b0,
        VC_BODY = 1'b1
    } vc_state_t;

endpackage
`default_nettype wire

// File: rtl/pkt_rx_proc_if.sv
`default_nettype none
// ============================================================================
// Module      : pkt_rx_proc_if
// Description : Router-to-NI flit channel plus NI-to-RX-buffer payload channel.
// Revision    : 1.0 - initial release
// ============================================================================
interface pkt_rx_proc_if
    import ravenoc_pkg::*;
#(
    parameter int NumVirtChn    = NocNumVirtChn,
    parameter int FlitWidth     = NocFlitWidth,
    parameter int FlitDataWidth = NocFlitDataWidth
);
    localparam int VcW = $clog2(NumVirtChn);

    logic                     flit_valid_i;
    logic [FlitWidth-1:0]     flit_data_i;
    logic [VcW-1:0]           flit_vc_i;
    logic                     flit_ready_o;

    logic                     rx_valid_o;
    logic [FlitDataWidth-1:0] rx_data_o;
    logic [VcW-1:0]           rx_vc_o;
    logic                     rx_last_o;
    logic                     rx_ready_i;

    modport slave (
        input  flit_valid_i, flit_data_i, flit_vc_i, rx_ready_i,
        output flit_ready_o, rx_valid_o, rx_data_o, rx_vc_o, rx_last_o
    );

    modport master (
        output flit_valid_i, flit_data_i, flit_vc_i, rx_ready_i,
        input  flit_ready_o, rx_valid_o, rx_data_o, rx_vc_o, rx_last_o
    );

endinterface
`default_nettype wire

// File: rtl/pkt_rx_proc_vc_fsm.sv
`default_nettype none
// ============================================================================
// Module      : pkt_rx_vc_fsm
// Description : Framing tracker for one virtual channel; flags forward/last
//               and framing errors for the flit currently being accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_rx_vc_fsm
    import ravenoc_pkg::*;
#(
    parameter int PktWidth = NocPktWidth
) (
    input  wire logic                clk_axi,
    input  wire logic                arst_axi,
    input  wire logic                i_sel,
    input  wire logic [1:0]          i_flit_type,
    input  wire logic [PktWidth-1:0] i_pkt_sz,
    output logic                     o_fwd,
    output logic                     o_last,
    output rx_err_t                  o_err
);

    vc_state_t           r_state;
    vc_state_t           w_state_nxt;
    logic [PktWidth-1:0] r_rem;
    logic [PktWidth-1:0] w_rem_nxt;

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            r_state <= VC_IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        o_fwd       = 1'b0;
        o_last      = 1'b0;
        o_err       = '0;
        if (i_sel) begin
            if (i_flit_type == HEAD_FLIT) begin
                // A head always opens a fresh packet, abandoning any open one
                o_fwd = 1'b1;
                o_err[RxErrUnexpHead] = (r_state == VC_BODY);
                if (i_pkt_sz == '0) begin
                    o_last      = 1'b1;
                    w_state_nxt = VC_IDLE;
                    w_rem_nxt   = '0;
                end else begin
                    w_state_nxt = VC_BODY;
                    w_rem_nxt   = i_pkt_sz;
                end
            end else if (i_flit_type == 2'b11 || r_state == VC_IDLE) begin
                o_err[RxErrOrphan] = 1'b1;
            end else if (i_flit_type == TAIL_FLIT) begin
                o_fwd       = 1'b1;
                o_last      = 1'b1;
                o_err[RxErrLen] = (r_rem != PktWidth'(1));
                w_state_nxt = VC_IDLE;
                w_rem_nxt   = '0;
            end else if (r_rem == PktWidth'(1)) begin
                // Body where the tail was due: close the packet anyway
                o_fwd       = 1'b1;
                o_last      = 1'b1;
                o_err[RxErrLen] = 1'b1;
                w_state_nxt = VC_IDLE;
                w_rem_nxt   = '0;
            end else begin
                o_fwd     = 1'b1;
                w_rem_nxt = r_rem - PktWidth'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pkt_rx_proc.sv
`default_nettype none
// ============================================================================
// Module      : pkt_rx_proc
// Description : NoC-to-AXI receive packet processor: per-VC framing checks,
//               type stripping, one-entry output stage, errors and counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_rx_proc
    import ravenoc_pkg::*;
#(
    parameter  int NumVirtChn    = NocNumVirtChn,
    parameter  int FlitWidth     = NocFlitWidth,
    parameter  int FlitDataWidth = NocFlitDataWidth,
    parameter  int PktWidth      = NocPktWidth,
    parameter  int XWidth        = NocXWidth,
    parameter  int YWidth        = NocYWidth,
    localparam int VcW           = $clog2(NumVirtChn)
) (
    input  wire logic       clk_axi,
    input  wire logic       arst_axi,
    pkt_rx_proc_if.slave    bus,
    output logic            pkt_done_o,
    output logic [VcW-1:0]  pkt_done_vc_o,
    output rx_err_t         err_o,
    input  wire logic       clr_err_i,
    output logic [15:0]     pkt_total_o
);

    logic [1:0]               w_flit_type;
    logic [PktWidth-1:0]      w_pkt_sz;
    logic                     w_accept;
    logic [NumVirtChn-1:0]    w_fwd_vc;
    logic [NumVirtChn-1:0]    w_last_vc;
    rx_err_t                  w_err_vc [NumVirtChn];
    rx_err_t                  w_err_set;
    logic                     w_pkt_done;

    logic                     r_out_valid;
    logic [FlitDataWidth-1:0] r_out_data;
    logic [VcW-1:0]           r_out_vc;
    logic                     r_out_last;
    rx_err_t                  r_err;
    logic [15:0]              r_pkt_total;

    assign w_flit_type      = bus.flit_data_i[FlitWidth-1 -: 2];
    assign w_pkt_sz         = bus.flit_data_i[FlitDataWidth-XWidth-YWidth-1 -: PktWidth];
    assign bus.flit_ready_o = ~r_out_valid | bus.rx_ready_i;
    assign w_accept         = bus.flit_valid_i & bus.flit_ready_o;

    for (genvar gi = 0; gi < NumVirtChn; gi++) begin : g_vc
        pkt_rx_vc_fsm #(
            .PktWidth    (PktWidth)
        ) u_vc_fsm (
            .clk_axi     (clk_axi),
            .arst_axi    (arst_axi),
            .i_sel       (w_accept && (bus.flit_vc_i == VcW'(gi))),
            .i_flit_type (w_flit_type),
            .i_pkt_sz    (w_pkt_sz),
            .o_fwd       (w_fwd_vc[gi]),
            .o_last      (w_last_vc[gi]),
            .o_err       (w_err_vc[gi])
        );
    end

    // Only the selected VC can raise strobes, so OR-reduction picks it out
    always_comb begin
        w_err_set = '0;
        for (int i = 0; i < NumVirtChn; i++) begin
            w_err_set = w_err_set | w_err_vc[i];
        end
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_vc    <= '0;
            r_out_last  <= 1'b0;
        end else if (|w_fwd_vc) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.flit_data_i[FlitDataWidth-1:0];
            r_out_vc    <= bus.flit_vc_i;
            r_out_last  <= |w_last_vc;
        end else if (bus.rx_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign w_pkt_done = r_out_valid & bus.rx_ready_i & r_out_last;

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            r_err       <= '0;
            r_pkt_total <= '0;
        end else begin
            r_err <= (clr_err_i ? rx_err_t'(0) : r_err) | w_err_set;
            if (w_pkt_done && r_pkt_total != 16'hFFFF) begin
                r_pkt_total <= r_pkt_total + 16'd1;
            end
        end
    end

    assign bus.rx_valid_o = r_out_valid;
    assign bus.rx_data_o  = r_out_data;
    assign bus.rx_vc_o    = r_out_vc;
    assign bus.rx_last_o  = r_out_last;
    assign pkt_done_o     = w_pkt_done;
    assign pkt_done_vc_o  = r_out_vc;
    assign err_o          = r_err;
    assign pkt_total_o    = r_pkt_total;

endmodule
`default_nettype wire

// File: tb/tb_pkt_rx_proc.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_rx_proc
// Description : Scoreboard bench for pkt_rx_proc with a packet-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_rx_proc;
    import ravenoc_pkg::*;

    logic        clk_axi   = 1'b0;
    logic        arst_axi  = 1'b1;
    logic        clr_err_i = 1'b0;
    logic        pkt_done_o;
    logic [1:0]  pkt_done_vc_o;
    rx_err_t     err_o;
    logic [15:0] pkt_total_o;

    pkt_rx_proc_if bus_if ();

    pkt_rx_proc dut (
        .clk_axi       (clk_axi),
        .arst_axi      (arst_axi),
        .bus           (bus_if),
        .pkt_done_o    (pkt_done_o),
        .pkt_done_vc_o (pkt_done_vc_o),
        .err_o         (err_o),
        .clr_err_i     (clr_err_i),
        .pkt_total_o   (pkt_total_o)
    );

    always #5 clk_axi = ~clk_axi;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [31:0] data;
        logic [1:0]  vc;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc_cnt = 0;
    always @(posedge clk_axi) cyc_cnt <= cyc_cnt + 1;

    // Packet-level reference: open packet, declared length, flits seen so far
    bit      m_open [3];
    int      m_len  [3];
    int      m_seen [3];
    rx_err_t m_err   = '0;
    int      m_total = 0;
    int      ready_mode = 0;

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_open[i] = 0; m_len[i] = 0; m_seen[i] = 0;
        end
        m_err = '0;
        m_total = 0;
        sb.delete();
    endtask

    task automatic model_accept(input int vc, input logic [1:0] t, input int sz, input logic [31:0] d);
        exp_t e;
        e.data = d; e.vc = vc[1:0]; e.cyc = cyc_cnt; e.last = 1'b0;
        if (t == HEAD_FLIT) begin
            if (m_open[vc]) m_err[0] = 1'b1;
            m_open[vc] = (sz != 0);
            m_len[vc]  = sz;
            m_seen[vc] = 0;
            e.last = (sz == 0);
            sb.push_back(e);
        end else if (t == 2'b11 || !m_open[vc]) begin
            m_err[1] = 1'b1;
        end else begin
            m_seen[vc]++;
            if (t == TAIL_FLIT) begin
                e.last = 1'b1;
                if (m_seen[vc] != m_len[vc]) m_err[2] = 1'b1;
            end else if (m_seen[vc] == m_len[vc]) begin
                e.last = 1'b1;
                m_err[2] = 1'b1;
            end
            if (e.last) m_open[vc] = 0;
            sb.push_back(e);
        end
    endtask

    function automatic logic [33:0] make_flit(input logic [1:0] t, input int sz);
        s_head_flit_t h;
        if (t == HEAD_FLIT) begin
            h.flit_type = HEAD_FLIT;
            h.x_dest    = NocXWidth'($urandom);
            h.y_dest    = NocYWidth'($urandom);
            h.pkt_sz    = NocPktWidth'(sz);
            h.payload   = NocPayloadW'($urandom);
            return h;
        end
        return {t, 32'($urandom)};
    endfunction

    task automatic send_flit(input int vc, input logic [1:0] t, input int sz);
        logic [33:0] f;
        int waited;
        bit done;
        waited = 0; done = 0;
        f = make_flit(t, sz);
        bus_if.flit_valid_i = 1'b1;
        bus_if.flit_data_i  = f;
        bus_if.flit_vc_i    = vc[1:0];
        while (!done) begin
            @(negedge clk_axi);
            if (bus_if.flit_ready_o) begin
                model_accept(vc, t, sz, f[31:0]);
                done = 1;
            end else if (++waited > 200) begin
                chk("flit_accept_timeout", bus_if.flit_ready_o, 1);
                done = 1;
            end
            @(posedge clk_axi); #1;
        end
        bus_if.flit_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_axi); #1; end
    endtask

    task automatic pulse_clr();
        clr_err_i = 1'b1;
        @(negedge clk_axi);
        m_err = '0;
        @(posedge clk_axi); #1;
        clr_err_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        ready_mode = 0;
        while ((sb.size() != 0 || bus_if.rx_valid_o) && n < 100) begin
            @(posedge clk_axi); #1;
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        idle(1);
    endtask

    task automatic do_reset();
        bus_if.flit_valid_i = 1'b0;
        arst_axi = 1'b1;
        model_clear();
        #1;
        chk("rst_rx_valid",  bus_if.rx_valid_o, 0);
        chk("rst_rx_data",   bus_if.rx_data_o, 0);
        chk("rst_rx_vc",     bus_if.rx_vc_o, 0);
        chk("rst_rx_last",   bus_if.rx_last_o, 0);
        chk("rst_pkt_done",  pkt_done_o, 0);
        chk("rst_err",       err_o, 0);
        chk("rst_pkt_total", pkt_total_o, 0);
        idle(2);
        arst_axi = 1'b0;
    endtask

    // Sink: RX buffer ready pattern
    initial begin
        bus_if.rx_ready_i = 1'b1;
        forever begin
            @(posedge clk_axi); #1;
            case (ready_mode)
                0:       bus_if.rx_ready_i = 1'b1;
                1:       bus_if.rx_ready_i = ($urandom_range(0, 3) != 0);
                default: bus_if.rx_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every rx transfer
    bit          hold = 0;
    bit          front_seen = 0;
    logic [31:0] p_data;
    logic [1:0]  p_vc;
    logic        p_last;
    exp_t        mon_e;

    initial begin
        forever begin
            @(negedge clk_axi);
            if (arst_axi) begin
                hold = 0;
                front_seen = 0;
            end else begin
                chk("flit_ready_rule", bus_if.flit_ready_o, !bus_if.rx_valid_o || bus_if.rx_ready_i);
                if (hold) begin
                    chk("hold_valid", bus_if.rx_valid_o, 1);
                    chk("hold_data", {bus_if.rx_vc_o, bus_if.rx_last_o, bus_if.rx_data_o}, {p_vc, p_last, p_data});
                end
                hold   = bus_if.rx_valid_o && !bus_if.rx_ready_i;
                p_data = bus_if.rx_data_o;
                p_vc   = bus_if.rx_vc_o;
                p_last = bus_if.rx_last_o;
                if (bus_if.rx_valid_o) begin
                    if (sb.size() == 0) begin
                        chk("rx_beat_not_expected", bus_if.rx_valid_o, 0);
                    end else begin
                        if (!front_seen) begin
                            chk("rx_latency", cyc_cnt, sb[0].cyc + 1);
                            front_seen = 1;
                        end
                        if (bus_if.rx_ready_i) begin
                            mon_e = sb.pop_front();
                            front_seen = 0;
                            chk("rx_data", bus_if.rx_data_o, mon_e.data);
                            chk("rx_vc",   bus_if.rx_vc_o, mon_e.vc);
                            chk("rx_last", bus_if.rx_last_o, mon_e.last);
                            chk("pkt_done", pkt_done_o, mon_e.last);
                            if (mon_e.last) begin
                                chk("pkt_done_vc", pkt_done_vc_o, mon_e.vc);
                                if (m_total < 65535) m_total++;
                            end
                        end
                    end
                end
                if (!(bus_if.rx_valid_o && bus_if.rx_ready_i)) chk("pkt_done_quiet", pkt_done_o, 0);
            end
        end
    end

    // Sticky errors and packet counter, compared once per cycle
    initial begin
        forever begin
            @(posedge clk_axi); #2;
            chk("err_o", err_o, m_err);
            chk("pkt_total", pkt_total_o, m_total);
        end
    end

    task automatic run_random(input int n_flits);
        int g_rem [3];
        int vc;
        int sz;
        logic [1:0] t;
        for (int i = 0; i < 3; i++) g_rem[i] = -1;
        ready_mode = 1;
        for (int n = 0; n < n_flits; n++) begin
            vc = $urandom_range(0, 2);
            sz = 0;
            if ($urandom_range(0, 29) == 0) begin
                t = 2'($urandom_range(0, 3));
                sz = $urandom_range(0, 3);
                g_rem[vc] = -1;
            end else if (g_rem[vc] < 0) begin
                t = HEAD_FLIT;
                sz = $urandom_range(0, 4);
                g_rem[vc] = (sz == 0) ? -1 : sz;
            end else if (g_rem[vc] == 1) begin
                t = TAIL_FLIT;
                g_rem[vc] = -1;
            end else begin
                t = BODY_FLIT;
                g_rem[vc]--;
            end
            send_flit(vc, t, sz);
            if ($urandom_range(0, 3) == 0) idle(1);
            if (n % 80 == 79) pulse_clr();
        end
    endtask

    initial begin
        bus_if.flit_valid_i = 1'b0;
        bus_if.flit_data_i  = '0;
        bus_if.flit_vc_i    = '0;
        model_clear();
        idle(3);
        do_reset();

        // Basic three-flit packet on VC0
        send_flit(0, HEAD_FLIT, 2);
        send_flit(0, BODY_FLIT, 0);
        send_flit(0, TAIL_FLIT, 0);
        drain();
        chk("t1_total", pkt_total_o, 1);
        chk("t1_err", err_o, 0);

        // Single-flit packet on VC2
        send_flit(2, HEAD_FLIT, 0);
        drain();
        chk("t2_total", pkt_total_o, 2);

        // Interleaved VC0/VC1
        send_flit(0, HEAD_FLIT, 2);
        send_flit(1, HEAD_FLIT, 2);
        send_flit(0, BODY_FLIT, 0);
        send_flit(1, BODY_FLIT, 0);
        send_flit(1, TAIL_FLIT, 0);
        send_flit(0, TAIL_FLIT, 0);
        drain();
        chk("t3_total", pkt_total_o, 4);
        chk("t3_err", err_o, 0);

        // Back-pressure for five cycles mid-packet
        ready_mode = 2;
        send_flit(0, HEAD_FLIT, 2);
        fork
            begin
                send_flit(0, BODY_FLIT, 0);
                send_flit(0, TAIL_FLIT, 0);
            end
            begin
                repeat (5) @(posedge clk_axi);
                #1;
                chk("stall_flit_ready", bus_if.flit_ready_o, 0);
                chk("stall_rx_valid", bus_if.rx_valid_o, 1);
                ready_mode = 0;
            end
        join
        drain();
        chk("t4_total", pkt_total_o, 5);

        // Orphan tail, clear, then premature tail
        send_flit(1, TAIL_FLIT, 0);
        idle(2);
        chk("orphan_err", err_o, 3'b010);
        pulse_clr();
        idle(1);
        chk("clr_err", err_o, 0);
        send_flit(1, HEAD_FLIT, 3);
        send_flit(1, TAIL_FLIT, 0);
        drain();
        chk("len_err", err_o, 3'b100);
        pulse_clr();

        // Head while a packet is open
        send_flit(0, HEAD_FLIT, 1);
        send_flit(0, HEAD_FLIT, 1);
        send_flit(0, TAIL_FLIT, 0);
        drain();
        chk("unexp_head_err", err_o, 3'b001);
        chk("t6_total", pkt_total_o, 7);
        pulse_clr();

        // Reset with an open packet and a pending output beat
        ready_mode = 2;
        send_flit(2, HEAD_FLIT, 3);
        idle(1);
        do_reset();
        ready_mode = 0;
        send_flit(2, TAIL_FLIT, 0);
        idle(2);
        chk("post_reset_orphan", err_o, 3'b010);
        pulse_clr();

        run_random(400);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
